// File: rtl/if_neuron_ctrl.sv
// Integrate-and-fire neuron array controller: sequences synaptic events, time-step and
// time-reference sweeps over neuron memory. Optional: IF_NEURON_CTRL_CNT_SAT_EN saturates spike count.
module if_neuron_ctrl #(
  parameter int N_NEUR = 256
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        syn_valid,
  output logic        syn_ready,
  input  logic [7:0]  syn_addr,
  input  logic [7:0]  syn_weight,
  input  logic        tstep_req,
  input  logic        tref_req,
  output logic        busy,
  output logic        sweep_done,
  output logic [7:0]  mem_addr,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [18:0] mem_wdata,
  input  logic [18:0] mem_rdata,
  output logic [11:0] nrn_state_core,
  output logic [6:0]  nrn_post_spike_cnt,
  output logic [7:0]  nrn_syn_weight,
  output logic        nrn_neuron_event,
  output logic        nrn_time_step_event,
  output logic        nrn_time_ref_event,
  input  logic [11:0] nrn_state_core_next,
  input  logic [6:0]  nrn_post_spike_cnt_next,
  input  logic        nrn_spike_out,
  output logic        aer_valid,
  input  logic        aer_ready,
  output logic [7:0]  aer_addr,
  output logic [2:0]  dbg_state_o
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SYN_RD = 3'd1;
  localparam logic [2:0] SYN_WR = 3'd2;
  localparam logic [2:0] TS_RD  = 3'd3;
  localparam logic [2:0] TS_WR  = 3'd4;
  localparam logic [2:0] TS_AER = 3'd5;
  localparam logic [2:0] TR_WR  = 3'd6;

  localparam logic [7:0] LAST_ADDR = 8'(N_NEUR - 1);

  logic [2:0]  state_q, state_d;
  logic        tstep_pend_q, tstep_pend_d;
  logic        tref_pend_q, tref_pend_d;
  logic [7:0]  sweep_addr_q, sweep_addr_d;
  logic [7:0]  syn_addr_q, syn_addr_d;
  logic [7:0]  syn_weight_q, syn_weight_d;
  logic        aer_valid_q, aer_valid_d;
  logic [7:0]  aer_addr_q, aer_addr_d;
  logic        done_q, done_d;

  logic        syn_ready_c, rd_en_c, wr_en_c;
  logic [7:0]  mem_addr_c, nrn_weight_c;
  logic [18:0] wdata_c;
  logic [11:0] nrn_state_c;
  logic [6:0]  nrn_cnt_c, ts_cnt;
  logic        ev_syn_c, ev_ts_c, ev_tr_c;
  logic        last_addr;

  assign last_addr = (sweep_addr_q == LAST_ADDR);

`ifdef IF_NEURON_CTRL_CNT_SAT_EN
  // A spiking neuron already at the top count stays there instead of wrapping.
  assign ts_cnt = ((mem_rdata[18:12] == 7'h7f) && nrn_spike_out) ? 7'h7f : nrn_post_spike_cnt_next;
`else
  assign ts_cnt = nrn_post_spike_cnt_next;
`endif

  always_comb begin
    state_d      = state_q;
    tstep_pend_d = tstep_pend_q | tstep_req;
    tref_pend_d  = tref_pend_q | tref_req;
    sweep_addr_d = sweep_addr_q;
    syn_addr_d   = syn_addr_q;
    syn_weight_d = syn_weight_q;
    aer_valid_d  = aer_valid_q;
    aer_addr_d   = aer_addr_q;
    done_d       = 1'b0;
    syn_ready_c  = 1'b0;
    rd_en_c      = 1'b0;
    wr_en_c      = 1'b0;
    mem_addr_c   = 8'd0;
    wdata_c      = 19'd0;
    nrn_state_c  = 12'd0;
    nrn_cnt_c    = 7'd0;
    nrn_weight_c = 8'd0;
    ev_syn_c     = 1'b0;
    ev_ts_c      = 1'b0;
    ev_tr_c      = 1'b0;
    case (state_q)
      IDLE: begin
        syn_ready_c = ~tstep_pend_q & ~tref_pend_q;
        if (tref_pend_q) begin
          tref_pend_d  = tref_req;
          sweep_addr_d = 8'd0;
          state_d      = TR_WR;
        end else if (tstep_pend_q) begin
          tstep_pend_d = tstep_req;
          sweep_addr_d = 8'd0;
          state_d      = TS_RD;
        end else if (syn_valid) begin
          syn_addr_d   = syn_addr;
          syn_weight_d = syn_weight;
          state_d      = SYN_RD;
        end
      end
      SYN_RD: begin
        rd_en_c    = 1'b1;
        mem_addr_c = syn_addr_q;
        state_d    = SYN_WR;
      end
      SYN_WR: begin
        ev_syn_c     = 1'b1;
        nrn_state_c  = mem_rdata[11:0];
        nrn_cnt_c    = mem_rdata[18:12];
        nrn_weight_c = syn_weight_q;
        wr_en_c      = 1'b1;
        mem_addr_c   = syn_addr_q;
        wdata_c      = {nrn_post_spike_cnt_next, nrn_state_core_next};
        state_d      = IDLE;
      end
      TS_RD: begin
        rd_en_c    = 1'b1;
        mem_addr_c = sweep_addr_q;
        state_d    = TS_WR;
      end
      TS_WR: begin
        ev_ts_c     = 1'b1;
        nrn_state_c = mem_rdata[11:0];
        nrn_cnt_c   = mem_rdata[18:12];
        wr_en_c     = 1'b1;
        mem_addr_c  = sweep_addr_q;
        wdata_c     = {ts_cnt, nrn_state_core_next};
        if (nrn_spike_out) begin
          aer_valid_d = 1'b1;
          aer_addr_d  = sweep_addr_q;
          state_d     = TS_AER;
        end else if (last_addr) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          sweep_addr_d = sweep_addr_q + 8'd1;
          state_d      = TS_RD;
        end
      end
      TS_AER: begin
        // The sweep holds here for as long as the spike consumer applies backpressure.
        if (aer_ready) begin
          aer_valid_d = 1'b0;
          if (last_addr) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            sweep_addr_d = sweep_addr_q + 8'd1;
            state_d      = TS_RD;
          end
        end
      end
      TR_WR: begin
        ev_tr_c    = 1'b1;
        wr_en_c    = 1'b1;
        mem_addr_c = sweep_addr_q;
        wdata_c    = {nrn_post_spike_cnt_next, nrn_state_core_next};
        if (last_addr) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          sweep_addr_d = sweep_addr_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      tstep_pend_q <= 1'b0;
      tref_pend_q  <= 1'b0;
      sweep_addr_q <= 8'd0;
      syn_addr_q   <= 8'd0;
      syn_weight_q <= 8'd0;
      aer_valid_q  <= 1'b0;
      aer_addr_q   <= 8'd0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tstep_pend_q <= tstep_pend_d;
      tref_pend_q  <= tref_pend_d;
      sweep_addr_q <= sweep_addr_d;
      syn_addr_q   <= syn_addr_d;
      syn_weight_q <= syn_weight_d;
      aer_valid_q  <= aer_valid_d;
      aer_addr_q   <= aer_addr_d;
      done_q       <= done_d;
    end
  end

  // Every output is forced low while reset is asserted, including registered ones.
  assign syn_ready           = ~RST & syn_ready_c;
  assign busy                = ~RST & (state_q != IDLE);
  assign sweep_done          = ~RST & done_q;
  assign mem_addr            = RST ? 8'd0 : mem_addr_c;
  assign mem_rd_en           = ~RST & rd_en_c;
  assign mem_wr_en           = ~RST & wr_en_c;
  assign mem_wdata           = RST ? 19'd0 : wdata_c;
  assign nrn_state_core      = RST ? 12'd0 : nrn_state_c;
  assign nrn_post_spike_cnt  = RST ? 7'd0 : nrn_cnt_c;
  assign nrn_syn_weight      = RST ? 8'd0 : nrn_weight_c;
  assign nrn_neuron_event    = ~RST & ev_syn_c;
  assign nrn_time_step_event = ~RST & ev_ts_c;
  assign nrn_time_ref_event  = ~RST & ev_tr_c;
  assign aer_valid           = ~RST & aer_valid_q;
  assign aer_addr            = RST ? 8'd0 : aer_addr_q;
  assign dbg_state_o         = RST ? IDLE : state_q;

endmodule

// File: tb/tb_if_neuron_ctrl.sv
// Bench for if_neuron_ctrl: memory and neuron models, write/spike scoreboard, scenario tasks.
module tb_if_neuron_ctrl;
  localparam int N = 4;
  localparam int W = 29;
`ifdef IF_NEURON_CTRL_CNT_SAT_EN
  localparam logic [6:0] SAT_CNT = 7'd127;
`else
  localparam logic [6:0] SAT_CNT = 7'd0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        syn_valid = 1'b0, syn_ready;
  logic [7:0]  syn_addr = 8'd0, syn_weight = 8'd0;
  logic        tstep_req = 1'b0, tref_req = 1'b0;
  logic        busy, sweep_done;
  logic [7:0]  mem_addr;
  logic        mem_rd_en, mem_wr_en;
  logic [18:0] mem_wdata;
  logic [18:0] mem_rdata = 19'd0;
  logic [11:0] nrn_state_core, nrn_state_core_next;
  logic [6:0]  nrn_post_spike_cnt, nrn_post_spike_cnt_next;
  logic [7:0]  nrn_syn_weight;
  logic        nrn_neuron_event, nrn_time_step_event, nrn_time_ref_event, nrn_spike_out;
  logic        aer_valid, aer_ready = 1'b1;
  logic [7:0]  aer_addr;
  logic [2:0]  dbg_state;

  int checks = 0;
  int passes = 0;
  int viol = 0;

  logic [18:0] mem [256];
  logic [18:0] ref_mem [256];
  logic [W-1:0] exp_q [$];
  logic [7:0]   aer_q [$];
  logic [W-1:0] mon_obs, mon_exp;
  logic [7:0]   mon_aer;
  logic [1:0]   mon_kind;
  logic [70:0]  out_bus;

  if_neuron_ctrl #(.N_NEUR(N)) dut (
    .CLK(CLK), .RST(RST),
    .syn_valid(syn_valid), .syn_ready(syn_ready), .syn_addr(syn_addr), .syn_weight(syn_weight),
    .tstep_req(tstep_req), .tref_req(tref_req), .busy(busy), .sweep_done(sweep_done),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .nrn_state_core(nrn_state_core), .nrn_post_spike_cnt(nrn_post_spike_cnt),
    .nrn_syn_weight(nrn_syn_weight), .nrn_neuron_event(nrn_neuron_event),
    .nrn_time_step_event(nrn_time_step_event), .nrn_time_ref_event(nrn_time_ref_event),
    .nrn_state_core_next(nrn_state_core_next), .nrn_post_spike_cnt_next(nrn_post_spike_cnt_next),
    .nrn_spike_out(nrn_spike_out),
    .aer_valid(aer_valid), .aer_ready(aer_ready), .aer_addr(aer_addr),
    .dbg_state_o(dbg_state)
  );

  always #5 CLK = ~CLK;

  assign out_bus = {syn_ready, busy, sweep_done, mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
                    nrn_state_core, nrn_post_spike_cnt, nrn_syn_weight, nrn_neuron_event,
                    nrn_time_step_event, nrn_time_ref_event, aer_valid, aer_addr};

  // Neuron: weight*4 integration, threshold 0x080 on time step, full clear on time reference.
  always_comb begin
    nrn_state_core_next     = 12'd0;
    nrn_post_spike_cnt_next = 7'd0;
    nrn_spike_out           = 1'b0;
    if (nrn_neuron_event) begin
      nrn_state_core_next     = nrn_state_core + {{2{nrn_syn_weight[7]}}, nrn_syn_weight, 2'b00};
      nrn_post_spike_cnt_next = nrn_post_spike_cnt;
    end else if (nrn_time_step_event) begin
      if (nrn_state_core >= 12'h080) begin
        nrn_spike_out           = 1'b1;
        nrn_post_spike_cnt_next = nrn_post_spike_cnt + 7'd1;
      end else begin
        nrn_state_core_next     = nrn_state_core;
        nrn_post_spike_cnt_next = nrn_post_spike_cnt;
      end
    end
  end

  always @(posedge CLK) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
  end

  always @(negedge CLK) begin
    if (!RST) begin
      if (32'(nrn_neuron_event) + 32'(nrn_time_step_event) + 32'(nrn_time_ref_event) > 1) viol++;
      if (mem_rd_en && mem_wr_en) viol++;
      if (mem_wr_en) begin
        mon_kind = nrn_neuron_event ? 2'd1 : nrn_time_step_event ? 2'd2 : nrn_time_ref_event ? 2'd3 : 2'd0;
        mon_obs  = {mon_kind, mem_addr, mem_wdata};
        checks++;
        if (exp_q.size() == 0) $display("FAIL mem_write_unexpected got %h expected none", mon_obs);
        else begin
          mon_exp = exp_q.pop_front();
          if (mon_obs !== mon_exp) $display("FAIL mem_write got %h expected %h", mon_obs, mon_exp);
          else passes++;
        end
      end
      if (aer_valid && aer_ready) begin
        checks++;
        if (aer_q.size() == 0) $display("FAIL aer_unexpected got addr %0d expected none", aer_addr);
        else begin
          mon_aer = aer_q.pop_front();
          if (aer_addr !== mon_aer) $display("FAIL aer_addr got %0d expected %0d", aer_addr, mon_aer);
          else passes++;
        end
      end
    end
  end

  function automatic logic [W-1:0] rec(input logic [1:0] k, input int a, input logic [18:0] d);
    return {k, 8'(a), d};
  endfunction

  task automatic set_neuron(input int a, input logic [6:0] c, input logic [11:0] s);
    mem[a] <= {c, s};
    ref_mem[a] = {c, s};
  endtask

  task automatic model_syn(input int a, input logic [7:0] w);
    int sv;
    sv = int'(ref_mem[a][11:0]) + 4 * int'($signed(w));
    ref_mem[a] = {ref_mem[a][18:12], 12'(sv)};
    exp_q.push_back(rec(2'd1, a, ref_mem[a]));
  endtask

  task automatic model_tstep();
    logic [6:0] c;
    for (int a = 0; a < N; a++) begin
      if (ref_mem[a][11:0] >= 12'h080) begin
        c = ref_mem[a][18:12];
        ref_mem[a] = {(c == 7'd127) ? SAT_CNT : c + 7'd1, 12'h000};
        aer_q.push_back(8'(a));
      end
      exp_q.push_back(rec(2'd2, a, ref_mem[a]));
    end
  endtask

  task automatic model_tref();
    for (int a = 0; a < N; a++) begin
      ref_mem[a] = 19'd0;
      exp_q.push_back(rec(2'd3, a, 19'd0));
    end
  endtask

  task automatic pulse(input logic ts, input logic tr);
    @(posedge CLK); #1;
    tstep_req = ts; tref_req = tr;
    @(posedge CLK); #1;
    tstep_req = 1'b0; tref_req = 1'b0;
  endtask

  task automatic send_syn(input int a, input logic [7:0] w);
    bit ok = 0;
    @(posedge CLK); #1;
    syn_valid = 1'b1; syn_addr = 8'(a); syn_weight = w;
    model_syn(a, w);
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (syn_ready) begin ok = 1; break; end
    end
    @(posedge CLK); #1;
    syn_valid = 1'b0;
    checks++;
    if (!ok) $display("FAIL syn_accept_timeout got ready=0 expected ready=1");
    else passes++;
  endtask

  task automatic wait_done(input int n, input bit rnd);
    int seen = 0;
    for (int i = 0; i < 3000 && seen < n; i++) begin
      @(posedge CLK); #1;
      if (rnd) aer_ready = 1'($urandom_range(0, 1));
      @(negedge CLK);
      if (sweep_done) seen++;
    end
    aer_ready = 1'b1;
    checks++;
    if (seen != n) $display("FAIL sweep_done_count got %0d expected %0d", seen, n);
    else passes++;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0 || aer_q.size() != 0)
      $display("FAIL %s_drained got %0d writes %0d spikes left expected 0 0", name, exp_q.size(), aer_q.size());
    else passes++;
    exp_q.delete(); aer_q.delete();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    for (int a = 0; a < 256; a++) set_neuron(a, 7'($urandom_range(0, 126)), 12'($urandom_range(0, 127)));
    repeat (3) @(negedge CLK);
    checks++;
    if (out_bus !== 71'd0) $display("FAIL reset_outputs got %h expected 0", out_bus);
    else passes++;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if ({syn_ready, busy, sweep_done} !== 3'b100) $display("FAIL reset_release got %b expected 100", {syn_ready, busy, sweep_done});
    else passes++;
  endtask

  task automatic test_syn_directed();
    set_neuron(5, 7'd0, 12'h000);
    @(posedge CLK); #1;
    syn_valid = 1'b1; syn_addr = 8'd5; syn_weight = 8'h10;
    model_syn(5, 8'h10);
    @(negedge CLK);
    checks++;
    if (syn_ready !== 1'b1) $display("FAIL syn_ready_idle got %b expected 1", syn_ready);
    else passes++;
    @(posedge CLK); #1;
    syn_valid = 1'b0;
    @(negedge CLK);
    checks++;
    if ({mem_rd_en, mem_wr_en, mem_addr} !== {1'b1, 1'b0, 8'd5})
      $display("FAIL syn_read_t1 got %b expected %b", {mem_rd_en, mem_wr_en, mem_addr}, {1'b1, 1'b0, 8'd5});
    else passes++;
    @(negedge CLK);
    checks++;
    if ({mem_rd_en, mem_wr_en, mem_addr, mem_wdata, nrn_neuron_event} !== {1'b0, 1'b1, 8'd5, 19'h00040, 1'b1})
      $display("FAIL syn_write_t2 got %h expected %h", {mem_rd_en, mem_wr_en, mem_addr, mem_wdata, nrn_neuron_event},
               {1'b0, 1'b1, 8'd5, 19'h00040, 1'b1});
    else passes++;
    @(negedge CLK);
    check_drained("syn_directed");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) send_syn($urandom_range(0, 15), 8'($urandom));
    repeat (4) @(negedge CLK);
    check_drained("back_to_back");
  endtask

  task automatic test_tstep_directed();
    set_neuron(0, 7'd0, 12'h100);
    set_neuron(1, 7'd0, 12'h000);
    set_neuron(2, 7'd0, 12'h100);
    set_neuron(3, 7'd0, 12'h000);
    model_tstep();
    pulse(1'b1, 1'b0);
    wait_done(1, 1'b0);
    check_drained("tstep_directed");
  endtask

  task automatic test_backpressure();
    bit seen = 0;
    bit stable = 1;
    set_neuron(0, 7'd3, 12'h0a0);
    for (int a = 1; a < N; a++) set_neuron(a, 7'd0, 12'($urandom_range(0, 127)));
    model_tstep();
    aer_ready = 1'b0;
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (aer_valid) begin seen = 1; break; end
    end
    checks++;
    if (!seen) $display("FAIL stall_aer_valid got 0 expected 1");
    else passes++;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if ({aer_valid, aer_addr, mem_rd_en, mem_wr_en, busy} !== {1'b1, 8'd0, 1'b0, 1'b0, 1'b1}) stable = 0;
    end
    checks++;
    if (!stable) $display("FAIL stall_hold got %b expected 1", stable);
    else passes++;
    aer_ready = 1'b1;
    wait_done(1, 1'b0);
    check_drained("backpressure");
  endtask

  task automatic test_coincident();
    int dn = 0;
    int hi = 0;
    send_syn(6, 8'($urandom));
    tstep_req = 1'b1; tref_req = 1'b1;
    model_tref();
    model_tstep();
    @(posedge CLK); #1;
    tstep_req = 1'b0; tref_req = 1'b0;
    for (int i = 0; i < 200 && dn < 2; i++) begin
      @(negedge CLK);
      if (sweep_done) dn++;
      if (dn < 2 && syn_ready) hi++;
    end
    checks++;
    if (dn != 2 || hi != 0) $display("FAIL coincident got done=%0d ready_hi=%0d expected done=2 ready_hi=0", dn, hi);
    else passes++;
    check_drained("coincident");
  endtask

  task automatic test_saturation();
    set_neuron(1, 7'd127, 12'h100);
    for (int a = 0; a < N; a++) if (a != 1) set_neuron(a, 7'd9, 12'($urandom_range(0, 127)));
    model_tstep();
    pulse(1'b1, 1'b0);
    wait_done(1, 1'b0);
    @(negedge CLK);
    checks++;
    if (mem[1] !== {SAT_CNT, 12'h000}) $display("FAIL sat_cnt got %h expected %h", mem[1], {SAT_CNT, 12'h000});
    else passes++;
    check_drained("saturation");
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 6; k++) send_syn($urandom_range(0, 7), 8'($urandom));
      model_tstep();
      pulse(1'b1, 1'b0);
      wait_done(1, 1'b1);
      if (r == 2) begin
        model_tref();
        pulse(1'b0, 1'b1);
        wait_done(1, 1'b1);
      end
      check_drained("random");
    end
  endtask

  task automatic test_reset_mid_aer();
    bit seen = 0;
    for (int a = 1; a < N; a++) set_neuron(a, 7'd1, 12'h010);
    set_neuron(0, 7'd4, 12'h200);
    ref_mem[0] = {7'd5, 12'h000};
    exp_q.push_back(rec(2'd2, 0, ref_mem[0]));
    aer_ready = 1'b0;
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (aer_valid) begin seen = 1; break; end
    end
    checks++;
    if (!seen) $display("FAIL rst_aer_valid got 0 expected 1");
    else passes++;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if (out_bus !== 71'd0) $display("FAIL rst_mid_outputs got %h expected 0", out_bus);
    else passes++;
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++;
    if (out_bus !== 71'd0) $display("FAIL rst_hold_outputs got %h expected 0", out_bus);
    else passes++;
    @(posedge CLK); #1;
    RST = 1'b0;
    aer_ready = 1'b1;
    @(negedge CLK);
    checks++;
    if ({syn_ready, busy} !== 2'b10) $display("FAIL rst_release_ready got %b expected 10", {syn_ready, busy});
    else passes++;
    repeat (20) @(negedge CLK);
    checks++;
    if (mem[1] !== 19'h01010 || mem[0] !== {7'd5, 12'h000}) $display("FAIL rst_mem got %h %h expected %h %h", mem[0], mem[1], {7'd5, 12'h000}, 19'h01010);
    else passes++;
    check_drained("reset_mid_aer");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_syn_directed();
    test_back_to_back();
    test_tstep_directed();
    test_backpressure();
    test_coincident();
    test_saturation();
    test_random();
    test_reset_mid_aer();
    checks++;
    if (viol != 0) $display("FAIL exclusivity got %0d violations expected 0", viol);
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/if_neuron_ctrl.md
IF_NEURON_CTRL -- requirements
Module: if_neuron_ctrl

Interface
REQ-001 SHALL have parameter N_NEUR, default 256, number of neurons swept (2..256); neuron address is always 8 bits.
REQ-002 SHALL have port CLK  in  1  system clock; all logic on rising edge.
REQ-003 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports syn_valid in 1, syn_ready out 1, syn_addr in 8, syn_weight in 8 signed: synaptic event handshake, target neuron and weight.
REQ-005 SHALL have ports tstep_req in 1 and tref_req in 1: single-cycle requests for a time-step sweep and a time-reference sweep.
REQ-006 SHALL have ports busy out 1 (not IDLE) and sweep_done out 1 (one-cycle pulse at the end of any sweep).
REQ-007 SHALL have ports mem_addr out 8, mem_rd_en out 1, mem_wr_en out 1, mem_wdata out 19 and mem_rdata in 19; word = {cnt[6:0], state[11:0]}; read data is valid the cycle after mem_rd_en.
REQ-008 SHALL have neuron-side outputs nrn_state_core 12, nrn_post_spike_cnt 7, nrn_syn_weight 8, nrn_neuron_event 1, nrn_time_step_event 1, nrn_time_ref_event 1.
REQ-009 SHALL have neuron-side inputs nrn_state_core_next 12, nrn_post_spike_cnt_next 7, nrn_spike_out 1; the neuron datapath is combinational.
REQ-010 SHALL have ports aer_valid out 1, aer_ready in 1, aer_addr out 8: output spike events.

Function
REQ-011 SHALL implement the states IDLE, SYN_RD, SYN_WR, TS_RD, TS_WR, TS_AER and TR_WR.
REQ-012 SHALL assert syn_ready only in IDLE with no pending sweep flag; on syn_valid&syn_ready, register addr and weight and go to SYN_RD.
REQ-013 SHALL, in SYN_RD, drive mem_rd_en=1 and mem_addr=addr, then go to SYN_WR.
REQ-014 SHALL, in SYN_WR, drive nrn_neuron_event=1 with nrn inputs taken from mem_rdata and the weight, write {cnt_next, state_next} (mem_wr_en=1), then go to IDLE; this is a 3-cycle occupancy and the write lands at accept cycle+2.
REQ-015 SHALL latch tstep_req and tref_req into pending flags in any state; repeated requests before service coalesce into one.
REQ-016 SHALL, in IDLE, apply the priority tref pending > tstep pending > syn event; starting a sweep clears its flag and zeros the sweep address.
REQ-017 SHALL run the time-step sweep as, per address 0..N_NEUR-1: TS_RD (read), then TS_WR (nrn_time_step_event=1, write back).
REQ-018 SHALL, if nrn_spike_out=1 in TS_WR, register aer_valid=1 and aer_addr=address and enter TS_AER; otherwise advance to the next address.
REQ-019 SHALL, in TS_AER, hold aer_valid and aer_addr stable until aer_ready, drop aer_valid on the handshake cycle, then advance; backpressure stalls the sweep indefinitely.
REQ-020 SHALL run the time-reference sweep in TR_WR with nrn_time_ref_event=1 and no read, writing the neuron outputs (zero) at one address per cycle.
REQ-021 SHALL, after the last address of either sweep, pulse sweep_done for one cycle and return to IDLE.
REQ-022 SHALL keep at most one nrn_*_event high in any cycle, and drive all nrn events to 0 outside SYN_WR, TS_WR and TR_WR.
REQ-023 SHALL drive mem_wr_en and mem_rd_en to 0 in every cycle where they are not required.

Reset
REQ-024 SHALL, while RST=1, go to IDLE, clear the pending flags, sweep address and registered addr/weight, and drive all outputs 0 (syn_ready=0).
REQ-025 SHALL abandon any operation in progress on a mid-operation reset, with no further memory writes and no restore of memory contents; syn_ready rises the first cycle after RST falls.

Configuration
REQ-026 SHALL support the macro IF_NEURON_CTRL_CNT_SAT_EN; when it is defined and the read cnt is 127 with nrn_spike_out=1 in TS_WR, the written cnt SHALL be 127.
REQ-027 SHALL, when IF_NEURON_CTRL_CNT_SAT_EN is undefined, write nrn_post_spike_cnt_next unmodified (127 wraps to 0).

Verification
REQ-028 SHALL cover: syn event addr=5, weight=0x10 with mem[5]={0,0x000}, neuron adds 0x040 -> mem_rd_en at T+1 and a write of {0,0x040} to address 5 at T+2.
REQ-029 SHALL cover: N_NEUR=4, states {0x100,0x000,0x100,0x000}, threshold 0x080, tstep_req -> aer events for addresses 0 and 2 in order, then sweep_done.
REQ-030 SHALL cover: aer_ready held 0 for 10 cycles during a spike -> aer_valid and aer_addr stable, no mem activity, sweep resumes after aer_ready.
REQ-031 SHALL cover: tstep_req and tref_req in the same cycle while busy -> tref sweep first, tstep sweep second, syn_ready low until both finish.
REQ-032 SHALL cover: cnt=127 spiking neuron -> written cnt 127 with the macro defined and 0 without it; and RST mid-TS_AER -> all outputs 0 next cycle with no further writes.
